serial_mod_scheduler: RTL and testbench

- Arbitrates two requesters that share one serial mod-multiple checker, which consumes one x bit and one y bit per clock and produces registered flag z.
- For each granted job: clears the checker, shifts a WIDTH-bit operand pair into it MSB-first, samples z after the last bit, and returns the flag to the requester that owns the job.
- Sits between the parallel host logic and the existing mod-multiple checker datapath.

---
 rtl/serial_mod_scheduler_pkg.sv | 6 +
 rtl/serial_mod_scheduler_rr_arbiter2.sv | 19 +
 rtl/serial_mod_scheduler.sv | 122 ++++++++++++
 tb/tb_serial_mod_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/serial_mod_scheduler_pkg.sv
// serial_mod_scheduler_pkg: FSM encoding and default sizing for the serial mod checker scheduler
package serial_mod_scheduler_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, WAIT = 2'd2, RESULT = 2'd3} state_e;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_CAP_DELAY = 1;
endpackage

// File: rtl/serial_mod_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; advancing points priority away from the last owner
module rr_arbiter2
   import serial_mod_scheduler_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       adv,
   input  logic       last_id,
   output logic [1:0] gnt
);
   logic ptr_q, ptr_d;
   always_comb begin
      ptr_d = adv ? ~last_id : ptr_q;
      gnt = (req[0] && !(req[1] && ptr_q)) ? 2'b01 : req[1] ? 2'b10 : 2'b00;
   end
   always_ff @(posedge clk)
      ptr_q <= !rst ? 1'b0 : ptr_d;
endmodule

// File: rtl/serial_mod_scheduler.sv
// serial_mod_scheduler: shares one serial mod-multiple checker between two requesters
module serial_mod_scheduler
   import serial_mod_scheduler_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CAP_DELAY = DEF_CAP_DELAY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] op_x0,
   input  logic [WIDTH-1:0] op_y0,
   input  logic [WIDTH-1:0] op_x1,
   input  logic [WIDTH-1:0] op_y1,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic             chk_clr,
   output logic             ser_x,
   output logic             ser_y,
   input  logic             chk_z,
   output logic             res_valid,
   output logic             res_id,
   output logic             res_z
);
   localparam int CW = $clog2(WIDTH);
   localparam int DW = $clog2(CAP_DELAY) + 1;
   state_e state_q, state_d;
   logic [WIDTH-1:0] sx_q, sx_d, sy_q, sy_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] dly_q, dly_d;
   logic id_q, id_d, ser_x_q, ser_x_d, ser_y_q, ser_y_d;
   logic res_valid_q, res_valid_d, res_id_q, res_id_d, res_z_q, res_z_d;
   logic [1:0] arb_gnt;
   rr_arbiter2 u_arb (
      .clk(clk),
      .rst(rst),
      .req(req),
      .adv(state_q == RESULT),
      .last_id(id_q),
      .gnt(arb_gnt)
   );
   // The grant is decided combinationally in IDLE so operands latch on the grant cycle's edge.
   assign gnt = (rst && state_q == IDLE) ? arb_gnt : 2'b00;
   assign chk_clr = |gnt;
   assign busy = (state_q != IDLE) || chk_clr;
   assign ser_x = ser_x_q;
   assign ser_y = ser_y_q;
   assign res_valid = res_valid_q;
   assign res_id = res_id_q;
   assign res_z = res_z_q;
   always_comb begin
      state_d = state_q;
      sx_d = sx_q;
      sy_d = sy_q;
      cnt_d = cnt_q;
      dly_d = dly_q;
      id_d = id_q;
      ser_x_d = 1'b0;
      ser_y_d = 1'b0;
      res_valid_d = 1'b0;
      res_id_d = res_id_q;
      res_z_d = res_z_q;
      case (state_q)
         IDLE: if (|gnt) begin
            id_d = gnt[1];
            sx_d = gnt[1] ? op_x1 : op_x0;
            sy_d = gnt[1] ? op_y1 : op_y0;
            ser_x_d = sx_d[WIDTH-1];
            ser_y_d = sy_d[WIDTH-1];
            cnt_d = CW'(WIDTH - 1);
            state_d = SHIFT;
         end
         SHIFT: begin
            sx_d = sx_q << 1;
            sy_d = sy_q << 1;
            ser_x_d = (cnt_q != '0) && sx_q[WIDTH-2];
            ser_y_d = (cnt_q != '0) && sy_q[WIDTH-2];
            cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
            if (cnt_q == '0) begin
               dly_d = DW'(CAP_DELAY - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            dly_d = (dly_q == '0) ? dly_q : dly_q - 1'b1;
            if (dly_q == '0) begin
               res_z_d = chk_z;
               res_id_d = id_q;
               res_valid_d = 1'b1;
               state_d = RESULT;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (!rst) begin
         state_q <= IDLE;
         sx_q <= '0;
         sy_q <= '0;
         cnt_q <= '0;
         dly_q <= '0;
         id_q <= 1'b0;
         ser_x_q <= 1'b0;
         ser_y_q <= 1'b0;
         res_valid_q <= 1'b0;
         res_id_q <= 1'b0;
         res_z_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sx_q <= sx_d;
         sy_q <= sy_d;
         cnt_q <= cnt_d;
         dly_q <= dly_d;
         id_q <= id_d;
         ser_x_q <= ser_x_d;
         ser_y_q <= ser_y_d;
         res_valid_q <= res_valid_d;
         res_id_q <= res_id_d;
         res_z_q <= res_z_d;
      end
endmodule

// File: tb/tb_serial_mod_scheduler.sv
// tb_serial_mod_scheduler: scoreboard bench for the default and a 4-bit/2-cycle scheduler
module tb_serial_mod_scheduler;
   typedef struct {logic id; logic [15:0] x; logic [15:0] y; int t;} job_t;
   logic clk = 1'b0, rst = 1'b0;
   logic [1:0][1:0] req;
   logic [1:0][15:0] ox0, oy0, ox1, oy1;
   wire [1:0][1:0] gnt;
   wire [1:0] busy, chk_clr, ser_x, ser_y, res_valid, res_id, res_z, chk_z;
   int vectors = 0, miscompares = 0;
   int pend [2] = '{0, 0};
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   serial_mod_scheduler #(.WIDTH(16), .CAP_DELAY(1)) u_dut16 (
      .clk(clk), .rst(rst), .req(req[0]),
      .op_x0(ox0[0]), .op_y0(oy0[0]), .op_x1(ox1[0]), .op_y1(oy1[0]),
      .gnt(gnt[0]), .busy(busy[0]), .chk_clr(chk_clr[0]), .ser_x(ser_x[0]), .ser_y(ser_y[0]),
      .chk_z(chk_z[0]), .res_valid(res_valid[0]), .res_id(res_id[0]), .res_z(res_z[0])
   );
   serial_mod_scheduler #(.WIDTH(4), .CAP_DELAY(2)) u_dut4 (
      .clk(clk), .rst(rst), .req(req[1]),
      .op_x0(ox0[1][3:0]), .op_y0(oy0[1][3:0]), .op_x1(ox1[1][3:0]), .op_y1(oy1[1][3:0]),
      .gnt(gnt[1]), .busy(busy[1]), .chk_clr(chk_clr[1]), .ser_x(ser_x[1]), .ser_y(ser_y[1]),
      .chk_z(chk_z[1]), .res_valid(res_valid[1]), .res_id(res_id[1]), .res_z(res_z[1])
   );

   for (genvar g = 0; g < 2; g++) begin : mon
      localparam int W = g ? 4 : 16;
      localparam int C = g ? 2 : 1;
      localparam logic [15:0] M = 16'((32'd1 << W) - 1);
      logic [1:0] zp = 2'b00;
      job_t q[$];
      job_t j;
      logic ptr = 1'b0, id;
      logic [15:0] sx, sy;
      int cyc = 0, nb = 99;
      // checker stub: z is x AND y delayed by the checker latency, cleared by chk_clr
      always @(posedge clk) zp <= chk_clr[g] ? 2'b00 : {zp[0], ser_x[g] & ser_y[g]};
      assign chk_z[g] = zp[C-1];
      always @(negedge clk) begin
         cyc++;
         if (!rst) begin
            ptr = 1'b0;
            q.delete();
            nb = W + 1;
            pend[g] = 0;
         end else begin
            if (nb < W) begin
               sx = {sx[14:0], ser_x[g]};
               sy = {sy[14:0], ser_y[g]};
               nb++;
            end else if (nb == W) begin
               chk("ser_idle", {ser_x[g], ser_y[g]}, 0);
               nb++;
            end
            if (gnt[g] != 2'b00) begin
               id = (req[g] == 2'b11) ? ptr : req[g][1];
               chk("gnt", gnt[g], (req[g] == 2'b00) ? 2'b00 : (id ? 2'b10 : 2'b01));
               j.id = id;
               j.x = (id ? ox1[g] : ox0[g]) & M;
               j.y = (id ? oy1[g] : oy0[g]) & M;
               j.t = cyc;
               q.push_back(j);
               pend[g]++;
               nb = 0;
               sx = '0;
               sy = '0;
            end
            if (res_valid[g]) begin
               if (q.size() == 0) chk("res_spurious", 1, 0);
               else begin
                  j = q.pop_front();
                  pend[g]--;
                  chk("latency", cyc - j.t, W + C + 1);
                  chk("res_id", res_id[g], j.id);
                  chk("res_z", res_z[g], j.x[0] & j.y[0]);
                  chk("ser_x_stream", sx, j.x);
                  chk("ser_y_stream", sy, j.y);
                  ptr = ~j.id;
               end
            end
         end
      end
   end

   task automatic wait_gnt(input int g, input string tag, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (gnt[g] == 2'b00 && n < 40);
      chk({tag, "_gnt_seen"}, gnt[g] != 2'b00, 1);
   endtask

   task automatic wait_res(input int g, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
         chk({tag, "_busy_nogrant"}, {busy[g], gnt[g]}, 3'b100);
      end while (!res_valid[g] && n < 40);
      chk({tag, "_res_seen"}, res_valid[g], 1);
   endtask

   task automatic job(input int g, input logic [1:0] r, input logic [15:0] x, input logic [15:0] y,
                      input string tag);
      int n;
      @(posedge clk);
      #1;
      if (r[1]) begin ox1[g] = x; oy1[g] = y; end
      else begin ox0[g] = x; oy0[g] = y; end
      req[g] = r;
      wait_gnt(g, tag, n);
      @(posedge clk);
      #1 req[g] = 2'b00;
      wait_res(g, tag);
   endtask

   initial begin
      int n;
      req = '0;
      ox0 = '0;
      oy0 = '0;
      ox1 = '0;
      oy1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", {gnt[0], busy[0], chk_clr[0], ser_x[0], ser_y[0], res_valid[0], res_id[0], res_z[0]}, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      job(0, 2'b01, 16'h3BC7, 16'h3BF8, "t1");
      job(0, 2'b10, 16'h0001, 16'h0001, "t2");
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      ox0[0] = 16'h1234;
      oy0[0] = 16'h00FF;
      ox1[0] = 16'hFFFF;
      oy1[0] = 16'h8001;
      req[0] = 2'b11;
      for (int k = 0; k < 3; k++) begin
         wait_gnt(0, "t3", n);
         if (k > 0) chk("t3_spacing", n, 1);
         if (k == 2) begin
            @(posedge clk);
            #1 req[0] = 2'b00;
         end
         wait_res(0, "t3");
      end
      @(posedge clk);
      #1 ox0[0] = 16'hFFFF;
      oy0[0] = 16'hFFFF;
      req[0] = 2'b01;
      wait_gnt(0, "t4", n);
      @(posedge clk);
      #1 req[0] = 2'b00;
      repeat (6) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 chk("t4_after_reset", {busy[0], ser_x[0], ser_y[0], res_valid[0]}, 0);
      rst = 1'b1;
      repeat (25) @(posedge clk);
      job(0, 2'b01, 16'hC001, 16'h8003, "t4b");
      @(posedge clk);
      #1 ox0[0] = 16'hA5C3;
      oy0[0] = 16'hFFFF;
      req[0] = 2'b01;
      wait_gnt(0, "t5", n);
      @(posedge clk);
      #1 req[0] = 2'b00;
      repeat (3) @(posedge clk);
      #1 ox0[0] = 16'h0000;
      oy0[0] = 16'h0001;
      req[0] = 2'b01;
      wait_res(0, "t5");
      wait_gnt(0, "t5_next", n);
      chk("t5_regrant_gap", n, 1);
      @(posedge clk);
      #1 req[0] = 2'b00;
      wait_res(0, "t5_next");
      job(1, 2'b01, 16'h000B, 16'h0007, "t6a");
      job(1, 2'b10, 16'h0006, 16'h000F, "t6b");
      @(negedge clk);
      chk("pending0", pend[0], 0);
      chk("pending1", pend[1], 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
